store_queue: RTL and testbench

- Parametrised successor to the single-entry-per-strand store buffer.
- Holds up to DEPTH pending store, flush and invalidate requests per strand, kept in per-strand FIFO order.
- Merges back-to-back stores to the same line into the tail entry. Forwards store data to loads from the same strand, merging all matching entries so that the youngest entry wins per byte.
- Sits between the dcache tag stage and the L2 request arbiter. Issues round-robin across strands, with at most one outstanding L2 request per strand.

---
 rtl/store_queue.sv | 273 +++++++++++++++++++++++++++
 tb/tb_store_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// Per-strand FIFO of pending store/flush/invalidate requests with same-line
// store coalescing, youngest-wins load forwarding and round-robin L2 issue.
module store_queue #(
  parameter int unsigned NUM_STRANDS = 4,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned CORE_ID     = 0,
  localparam int unsigned SW = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1,
  localparam int unsigned DW = 8 * LINE_BYTES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [2:0]            req_op,
  input  logic [SW-1:0]         req_strand,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DW-1:0]         req_data,
  input  logic [LINE_BYTES-1:0] req_mask,
  output logic [DW-1:0]         fwd_data,
  output logic [LINE_BYTES-1:0] fwd_mask,
  output logic                  rollback_o,
  output logic [NUM_STRANDS-1:0] resume_strands,
  output logic                  l2req_valid,
  input  logic                  l2req_ready,
  output logic [2:0]            l2req_op,
  output logic [SW-1:0]         l2req_strand,
  output logic [ADDR_WIDTH-1:0] l2req_addr,
  output logic [DW-1:0]         l2req_data,
  output logic [LINE_BYTES-1:0] l2req_mask,
  output logic [3:0]            l2req_core,
  input  logic                  l2rsp_valid,
  input  logic [SW-1:0]         l2rsp_strand
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_FLUSH = 3'd2,
    OP_DINV  = 3'd3,
    OP_IINV  = 3'd4,
    OP_STBAR = 3'd5
  } op_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  // Entry storage
  logic                  valid_q  [NUM_STRANDS][DEPTH];
  logic                  valid_d  [NUM_STRANDS][DEPTH];
  logic                  issued_q [NUM_STRANDS][DEPTH];
  logic                  issued_d [NUM_STRANDS][DEPTH];
  logic [2:0]            op_q     [NUM_STRANDS][DEPTH];
  logic [2:0]            op_d     [NUM_STRANDS][DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q   [NUM_STRANDS][DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d   [NUM_STRANDS][DEPTH];
  logic [DW-1:0]         data_q   [NUM_STRANDS][DEPTH];
  logic [DW-1:0]         data_d   [NUM_STRANDS][DEPTH];
  logic [LINE_BYTES-1:0] mask_q   [NUM_STRANDS][DEPTH];
  logic [LINE_BYTES-1:0] mask_d   [NUM_STRANDS][DEPTH];

  // Per-strand control
  logic [PW-1:0]          head_q  [NUM_STRANDS];
  logic [PW-1:0]          head_d  [NUM_STRANDS];
  logic [PW-1:0]          tail_q  [NUM_STRANDS];
  logic [PW-1:0]          tail_d  [NUM_STRANDS];
  logic [CW-1:0]          count_q [NUM_STRANDS];
  logic [CW-1:0]          count_d [NUM_STRANDS];
  logic [NUM_STRANDS-1:0] wait_q, wait_d;
  logic [SW-1:0]          rr_q, rr_d;

  // Registered outputs
  logic [DW-1:0]          fwd_data_q, fwd_data_d;
  logic [LINE_BYTES-1:0]  fwd_mask_q, fwd_mask_d;
  logic                   rollback_q, rollback_d;
  logic [NUM_STRANDS-1:0] resume_q, resume_d;

  // Decode
  op_e                    req_op_e;
  logic [SW-1:0]          qs, rs;
  logic [PW-1:0]          tl;
  logic                   ack_ok, ack_here, accept, is_enq;
  logic                   coalesce, alloc, full, stbar_block;
  logic [NUM_STRANDS-1:0] cand;
  logic [SW-1:0]          gnt;
  logic                   any_cand;

  assign req_op_e = op_e'(req_op);
  assign qs       = req_strand;
  assign rs       = l2rsp_strand;

  always_comb begin
    for (int unsigned s = 0; s < NUM_STRANDS; s++) begin
      cand[s] = valid_q[s][head_q[s]] && !issued_q[s][head_q[s]];
    end
  end

  // Priority starts at the strand after the last accepted grant.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt      = rr_q;
    any_cand = 1'b0;
    for (int unsigned i = 1; i <= NUM_STRANDS; i++) begin
      idx = (32'(rr_q) + i) % NUM_STRANDS;
      if (!any_cand && cand[idx]) begin
        gnt      = SW'(idx);
        any_cand = 1'b1;
      end
    end
  end

  assign l2req_valid  = any_cand;
  assign l2req_strand = gnt;
  assign l2req_op     = op_q[gnt][head_q[gnt]];
  assign l2req_addr   = addr_q[gnt][head_q[gnt]];
  assign l2req_data   = data_q[gnt][head_q[gnt]];
  assign l2req_mask   = mask_q[gnt][head_q[gnt]];
  assign l2req_core   = 4'(CORE_ID);

  // A head accepted this cycle has already left with its old data, so a
  // store that would merge into it must allocate instead.
  always_comb begin
    ack_ok   = l2rsp_valid && valid_q[rs][head_q[rs]] && issued_q[rs][head_q[rs]];
    accept   = l2req_valid && l2req_ready;
    ack_here = ack_ok && (rs == qs);
    is_enq   = req_valid && (req_op_e == OP_STORE || req_op_e == OP_FLUSH ||
                             req_op_e == OP_DINV  || req_op_e == OP_IINV);
    tl       = ptr_dec(tail_q[qs]);
    coalesce = is_enq && (req_op_e == OP_STORE) && valid_q[qs][tl] &&
               !issued_q[qs][tl] && (op_q[qs][tl] == OP_STORE) &&
               (addr_q[qs][tl] == req_addr) &&
               !(accept && (gnt == qs) && (tl == head_q[qs]));
    alloc    = is_enq && !coalesce &&
               ((count_q[qs] != CW'(DEPTH)) || ack_here);
    full     = is_enq && !coalesce && !alloc;
    stbar_block = req_valid && (req_op_e == OP_STBAR) &&
                  ((count_q[qs] - CW'(ack_here)) != '0);
  end

  always_comb begin
    logic [PW-1:0] fidx;
    valid_d    = valid_q;
    issued_d   = issued_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wait_d     = wait_q;
    rr_d       = rr_q;
    rollback_d = 1'b0;
    resume_d   = '0;
    fwd_data_d = '0;
    fwd_mask_d = '0;
    fidx       = '0;

    if (accept) begin
      issued_d[gnt][head_q[gnt]] = 1'b1;
      rr_d = gnt;
    end

    if (ack_ok) begin
      valid_d[rs][head_q[rs]]  = 1'b0;
      issued_d[rs][head_q[rs]] = 1'b0;
      head_d[rs]  = ptr_inc(head_q[rs]);
      count_d[rs] = count_q[rs] - CW'(1);
      if (wait_q[rs]) begin
        wait_d[rs]   = 1'b0;
        resume_d[rs] = 1'b1;
      end
    end

    if (coalesce) begin
      for (int unsigned b = 0; b < LINE_BYTES; b++) begin
        if (req_mask[b]) data_d[qs][tl][8*b +: 8] = req_data[8*b +: 8];
      end
      mask_d[qs][tl] = mask_q[qs][tl] | req_mask;
    end

    if (alloc) begin
      valid_d[qs][tail_q[qs]]  = 1'b1;
      issued_d[qs][tail_q[qs]] = 1'b0;
      op_d[qs][tail_q[qs]]     = req_op;
      addr_d[qs][tail_q[qs]]   = req_addr;
      data_d[qs][tail_q[qs]]   = req_data;
      mask_d[qs][tail_q[qs]]   = (req_op_e == OP_STORE) ? req_mask : '0;
      tail_d[qs]  = ptr_inc(tail_q[qs]);
      count_d[qs] = count_d[qs] + CW'(1);
    end

    if (full || stbar_block) begin
      rollback_d = 1'b1;
      wait_d[qs] = 1'b1;
    end

    // Walk oldest to youngest so younger bytes overwrite older ones.
    if (req_valid && req_op_e == OP_LOAD) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        fidx = head_q[qs] + PW'(k);
        if ((CW'(k) < count_q[qs]) && valid_q[qs][fidx] && (addr_q[qs][fidx] == req_addr)) begin
          for (int unsigned b = 0; b < LINE_BYTES; b++) begin
            if (mask_q[qs][fidx][b]) fwd_data_d[8*b +: 8] = data_q[qs][fidx][8*b +: 8];
          end
          fwd_mask_d = fwd_mask_d | mask_q[qs][fidx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUM_STRANDS; s++) begin
        head_q[s]  <= '0;
        tail_q[s]  <= '0;
        count_q[s] <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          valid_q[s][d]  <= 1'b0;
          issued_q[s][d] <= 1'b0;
        end
      end
      wait_q     <= '0;
      rr_q       <= '0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      rollback_q <= 1'b0;
      resume_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      issued_q   <= issued_d;
      wait_q     <= wait_d;
      rr_q       <= rr_d;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
      rollback_q <= rollback_d;
      resume_q   <= resume_d;
    end
  end

  // Payload fields are qualified by valid and need no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign fwd_data       = fwd_data_q;
  assign fwd_mask       = fwd_mask_q;
  assign rollback_o     = rollback_q;
  assign resume_strands = resume_q;

  a_req_op_legal: assert property (@(posedge clk) disable iff (!reset)
    req_valid |-> (req_op <= 3'd5));

  // Empty strands tolerate stale acks for requests lost across a reset.
  a_ack_issued: assert property (@(posedge clk) disable iff (!reset)
    (l2rsp_valid && (count_q[l2rsp_strand] != '0)) |-> issued_q[l2rsp_strand][head_q[l2rsp_strand]]);

endmodule

// File: tb/tb_store_queue.sv
// Directed testbench for store_queue: rollback/resume, coalescing,
// forwarding, round-robin issue, simultaneous ack and reset.
module tb_store_queue;
  localparam int NS = 4;
  localparam int LB = 64;
  localparam int DW = 8 * LB;
  localparam int AW = 26;

  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] STORE = 3'd1;
  localparam logic [2:0] STBAR = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [1:0]    req_strand;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [LB-1:0] req_mask;
  logic [DW-1:0] fwd_data;
  logic [LB-1:0] fwd_mask;
  logic          rollback_o;
  logic [NS-1:0] resume_strands;
  logic          l2req_valid;
  logic          l2req_ready;
  logic [2:0]    l2req_op;
  logic [1:0]    l2req_strand;
  logic [AW-1:0] l2req_addr;
  logic [DW-1:0] l2req_data;
  logic [LB-1:0] l2req_mask;
  logic [3:0]    l2req_core;
  logic          l2rsp_valid;
  logic [1:0]    l2rsp_strand;

  int vectors = 0;
  int miscompares = 0;

  store_queue #(.NUM_STRANDS(4), .DEPTH(2), .LINE_BYTES(64), .ADDR_WIDTH(26), .CORE_ID(0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_strand(req_strand),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .fwd_data(fwd_data), .fwd_mask(fwd_mask), .rollback_o(rollback_o),
    .resume_strands(resume_strands),
    .l2req_valid(l2req_valid), .l2req_ready(l2req_ready), .l2req_op(l2req_op),
    .l2req_strand(l2req_strand), .l2req_addr(l2req_addr), .l2req_data(l2req_data),
    .l2req_mask(l2req_mask), .l2req_core(l2req_core),
    .l2rsp_valid(l2rsp_valid), .l2rsp_strand(l2rsp_strand)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] st, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [LB-1:0] m);
    req_valid  = 1'b1;
    req_op     = op;
    req_strand = st;
    req_addr   = a;
    req_data   = d;
    req_mask   = m;
    tick();
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_mask   = '0;
  endtask

  task automatic accept_one();
    l2req_ready = 1'b1;
    tick();
    l2req_ready = 1'b0;
  endtask

  task automatic ack(input logic [1:0] st);
    l2rsp_valid  = 1'b1;
    l2rsp_strand = st;
    tick();
    l2rsp_valid  = 1'b0;
  endtask

  task automatic drain();
    logic [1:0] st;
    for (int i = 0; i < 40 && l2req_valid; i++) begin
      st = l2req_strand;
      accept_one();
      ack(st);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_strand = '0; req_addr = '0;
    req_data = '0; req_mask = '0; l2req_ready = 1'b0; l2rsp_valid = 1'b0; l2rsp_strand = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (fwd_mask !== '0) begin miscompares++; $display("FAIL reset_fwd_mask: got %h want 0", fwd_mask); end
    vectors++; if (fwd_data !== '0) begin miscompares++; $display("FAIL reset_fwd_data: got nonzero want 0"); end
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL reset_rollback: got %b want 0", rollback_o); end
    vectors++; if (resume_strands !== 4'b0) begin miscompares++; $display("FAIL reset_resume: got %b want 0000", resume_strands); end
    vectors++; if (l2req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_l2req_valid: got %b want 0", l2req_valid); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_rollback();
    send(STORE, 2'd1, 26'h10, DW'(32'h1010), 64'h1);
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL first_store_rollback: got %b want 0", rollback_o); end
    send(STORE, 2'd1, 26'h20, DW'(32'h2020), 64'h1);
    send(STORE, 2'd1, 26'h30, DW'(32'h3030), 64'h1);
    vectors++; if (rollback_o !== 1'b1) begin miscompares++; $display("FAIL full_rollback: got %b want 1", rollback_o); end
    vectors++; if (l2req_valid !== 1'b1 || l2req_strand !== 2'd1 || l2req_addr !== 26'h10)
      begin miscompares++; $display("FAIL full_head_req: got v=%b s=%0d a=%h want v=1 s=1 a=10", l2req_valid, l2req_strand, l2req_addr); end
    accept_one();
    vectors++; if (l2req_valid !== 1'b0) begin miscompares++; $display("FAIL issued_head_not_candidate: got %b want 0", l2req_valid); end
    ack(2'd1);
    vectors++; if (resume_strands !== 4'b0010) begin miscompares++; $display("FAIL resume_pulse: got %b want 0010", resume_strands); end
    tick();
    vectors++; if (resume_strands !== 4'b0000) begin miscompares++; $display("FAIL resume_one_cycle: got %b want 0000", resume_strands); end
    vectors++; if (l2req_addr !== 26'h20) begin miscompares++; $display("FAIL next_head_addr: got %h want 20", l2req_addr); end
    send(STORE, 2'd1, 26'h30, DW'(32'h3030), 64'h1);
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL retry_rollback: got %b want 0", rollback_o); end
    drain();
  endtask

  task automatic test_coalesce();
    logic [DW-1:0] a_data, b_data;
    a_data = {LB{8'hAA}};
    b_data = {LB{8'hBB}};
    send(STORE, 2'd0, 26'h40, a_data, 64'h0F);
    send(STORE, 2'd0, 26'h40, b_data, 64'hF0);
    vectors++; if (l2req_mask !== 64'hFF) begin miscompares++; $display("FAIL coalesce_mask: got %h want ff", l2req_mask); end
    vectors++; if (l2req_data[63:0] !== 64'hBBBBBBBB_AAAAAAAA) begin miscompares++; $display("FAIL coalesce_data: got %h want bbbbbbbbaaaaaaaa", l2req_data[63:0]); end
    vectors++; if (l2req_op !== STORE || l2req_core !== 4'd0) begin miscompares++; $display("FAIL coalesce_op_core: got op=%0d core=%0d want 1 0", l2req_op, l2req_core); end
    accept_one();
    vectors++; if (l2req_valid !== 1'b0) begin miscompares++; $display("FAIL coalesce_single_entry: got %b want 0", l2req_valid); end
    ack(2'd0);
    drain();
  endtask

  task automatic test_forward();
    send(STORE, 2'd2, 26'h50, DW'(16'h11AA), 64'h3);
    accept_one();
    send(STORE, 2'd2, 26'h50, DW'(16'h22BB), 64'h1);
    send(LOAD, 2'd2, 26'h50, '0, '0);
    vectors++; if (fwd_mask !== 64'h3) begin miscompares++; $display("FAIL fwd_mask_merge: got %h want 3", fwd_mask); end
    vectors++; if (fwd_data !== DW'(16'h11BB)) begin miscompares++; $display("FAIL fwd_youngest_wins: got %h want 11bb", fwd_data[15:0]); end
    send(LOAD, 2'd3, 26'h50, '0, '0);
    vectors++; if (fwd_mask !== '0 || fwd_data !== '0) begin miscompares++; $display("FAIL fwd_other_strand: got mask %h want 0", fwd_mask); end
    send(LOAD, 2'd2, 26'h51, '0, '0);
    vectors++; if (fwd_mask !== '0) begin miscompares++; $display("FAIL fwd_addr_mismatch: got %h want 0", fwd_mask); end
    ack(2'd2);
    drain();
  endtask

  task automatic test_round_robin();
    l2req_ready = 1'b1;
    for (int s = 0; s < NS; s++) begin
      send(STORE, 2'(s), 26'h60 + 26'(s), DW'(s), 64'h1);
      vectors++; if (l2req_valid !== 1'b1 || l2req_strand !== 2'(s))
        begin miscompares++; $display("FAIL rr_back_to_back: got v=%b s=%0d want 1 %0d", l2req_valid, l2req_strand, s); end
    end
    tick();
    l2req_ready = 1'b0;
    for (int s = 0; s < NS; s++) ack(2'(s));
    // last grant was strand 3, so the order restarts at 0 regardless of enqueue order
    for (int s = NS - 1; s >= 0; s--) send(STORE, 2'(s), 26'h70 + 26'(s), DW'(32'hC0DE0070 + s), 64'h1);
    for (int c = 0; c < 3; c++) begin
      vectors++; if (l2req_strand !== 2'd0 || l2req_addr !== 26'h70 || l2req_data !== DW'(32'hC0DE0070))
        begin miscompares++; $display("FAIL stall_stable: cycle %0d got s=%0d a=%h want s=0 a=70", c, l2req_strand, l2req_addr); end
      tick();
    end
    for (int s = 0; s < NS; s++) begin
      vectors++; if (l2req_valid !== 1'b1 || l2req_strand !== 2'(s))
        begin miscompares++; $display("FAIL rr_order: got s=%0d want %0d", l2req_strand, s); end
      accept_one();
    end
    for (int s = 0; s < NS; s++) ack(2'(s));
  endtask

  task automatic test_full_ack_same_cycle();
    send(STORE, 2'd0, 26'h90, DW'(32'h90), 64'h1);
    send(STORE, 2'd0, 26'h91, DW'(32'h91), 64'h1);
    accept_one();
    l2rsp_valid = 1'b1; l2rsp_strand = 2'd0;
    send(STORE, 2'd0, 26'h92, DW'(32'h92), 64'h1);
    l2rsp_valid = 1'b0;
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL full_with_ack: got %b want 0", rollback_o); end
    vectors++; if (l2req_strand !== 2'd0 || l2req_addr !== 26'h91) begin miscompares++; $display("FAIL after_ack_head: got a=%h want 91", l2req_addr); end
    send(STBAR, 2'd1, '0, '0, '0);
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL stbar_empty: got %b want 0", rollback_o); end
    accept_one();
    ack(2'd0);
    send(STBAR, 2'd0, '0, '0, '0);
    vectors++; if (rollback_o !== 1'b1) begin miscompares++; $display("FAIL stbar_pending: got %b want 1", rollback_o); end
    accept_one();
    ack(2'd0);
    vectors++; if (resume_strands !== 4'b0001) begin miscompares++; $display("FAIL stbar_resume: got %b want 0001", resume_strands); end
    send(STORE, 2'd0, 26'hA0, DW'(32'hA0), 64'h1);
    accept_one();
    l2rsp_valid = 1'b1; l2rsp_strand = 2'd0;
    send(STBAR, 2'd0, '0, '0, '0);
    l2rsp_valid = 1'b0;
    vectors++; if (rollback_o !== 1'b0) begin miscompares++; $display("FAIL stbar_with_ack: got %b want 0", rollback_o); end
    drain();
  endtask

  task automatic test_reset_issued();
    send(STORE, 2'd2, 26'h80, DW'(32'h80), 64'h1);
    accept_one();
    send(STORE, 2'd2, 26'h82, DW'(32'h82), 64'h1);
    send(STORE, 2'd2, 26'h83, DW'(32'h83), 64'h1);
    #2 reset = 1'b0;
    #1;
    vectors++; if (l2req_valid !== 1'b0 || rollback_o !== 1'b0)
      begin miscompares++; $display("FAIL async_reset: got v=%b rb=%b want 0 0", l2req_valid, rollback_o); end
    @(posedge clk);
    #1 reset = 1'b1;
    ack(2'd2);
    vectors++; if (resume_strands !== 4'b0 || l2req_valid !== 1'b0)
      begin miscompares++; $display("FAIL stale_ack: got resume=%b v=%b want 0000 0", resume_strands, l2req_valid); end
    send(LOAD, 2'd2, 26'h80, '0, '0);
    vectors++; if (fwd_mask !== '0) begin miscompares++; $display("FAIL reset_cleared_entries: got %h want 0", fwd_mask); end
    send(STORE, 2'd0, 26'hB0, DW'(32'hB0), 64'h1);
    send(STORE, 2'd1, 26'hB1, DW'(32'hB1), 64'h1);
    vectors++; if (l2req_strand !== 2'd1) begin miscompares++; $display("FAIL rr_after_reset: got %0d want 1", l2req_strand); end
    drain();
    vectors++; if (l2req_valid !== 1'b0) begin miscompares++; $display("FAIL final_drain: got %b want 0", l2req_valid); end
  endtask

  initial begin
    test_reset();
    test_full_rollback();
    test_coalesce();
    test_forward();
    test_round_robin();
    test_full_ack_same_cycle();
    test_reset_issued();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
